// File: rtl/hamming_decoder_fsm.sv
// Hamming(7,4) single-error-correcting decoder.
// Four-state FSM with valid/ready ports and saturating word/error counters.
module hamming_decoder_fsm #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_data,
  output logic             out_err,
  output logic [2:0]       out_err_pos,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CHECK = 2'd1;
  localparam logic [1:0] FIX   = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [6:0]       code_q;
  logic [2:0]       syn_q, syn_d;
  logic [3:0]       data_q, data_d;
  logic             err_q;
  logic [2:0]       pos_q;
  logic             valid_q;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0] ecnt_q, ecnt_d;
  logic             xfer;

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = valid_q;
  assign out_data    = data_q;
  assign out_err     = err_q;
  assign out_err_pos = pos_q;
  assign word_cnt    = wcnt_q;
  assign err_cnt     = ecnt_q;

  assign xfer = (state_q == HOLD) && out_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (in_valid) state_d = CHECK;
      CHECK: state_d = FIX;
      FIX:   state_d = HOLD;
      HOLD:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    syn_d[0] = code_q[0] ^ code_q[2] ^ code_q[4] ^ code_q[6];
    syn_d[1] = code_q[1] ^ code_q[2] ^ code_q[5] ^ code_q[6];
    syn_d[2] = code_q[3] ^ code_q[4] ^ code_q[5] ^ code_q[6];
  end

  // Only data positions 3,5,6,7 matter; a parity-bit hit leaves data alone.
  always_comb begin
    data_d[0] = code_q[2] ^ (syn_q == 3'd3);
    data_d[1] = code_q[4] ^ (syn_q == 3'd5);
    data_d[2] = code_q[5] ^ (syn_q == 3'd6);
    data_d[3] = code_q[6] ^ (syn_q == 3'd7);
  end

  always_comb begin
    wcnt_d = wcnt_q;
    ecnt_d = ecnt_q;
    if (cnt_clr) begin
      wcnt_d = '0;
      ecnt_d = '0;
    end else if (xfer) begin
      if (wcnt_q != CNT_MAX) wcnt_d = wcnt_q + CNT_ONE;
      if (err_q && ecnt_q != CNT_MAX) ecnt_d = ecnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= '0;
      syn_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      pos_q   <= '0;
      valid_q <= 1'b0;
      wcnt_q  <= '0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      ecnt_q  <= ecnt_d;
      if (state_q == IDLE && in_valid) code_q <= in_code;
      if (state_q == CHECK) syn_q <= syn_d;
      if (state_q == FIX) begin
        data_q  <= data_d;
        err_q   <= |syn_q;
        pos_q   <= syn_q;
        valid_q <= 1'b1;
      end else if (xfer) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule
